// File: rtl/wb_master_bridge.sv
// Pipeline-to-Wishbone B4 classic master bridge.
// Latches one read/write request from the core pipeline, runs a classic
// Wishbone cycle, re-issues after slave errors up to MAX_RETRY times and
// aborts with a timeout indication if the slave never answers.
module wb_master_bridge #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int SELW      = DW / 8,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 255,
    parameter int TW        = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // pipeline side
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic [AW-1:0]   wbm_addr_i,
    input  logic [SELW-1:0] wbm_sel_i,
    input  logic            wbm_we_i,
    input  logic            wbm_re_i,
    output logic            wbm_ack_o,
    output logic            wbm_err_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic            wbm_busy_o,
    output logic            wbm_timeout_o,
    // Wishbone side
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic [AW-1:0]   wbs_addr_o,
    output logic            wbs_we_o,
    output logic [SELW-1:0] wbs_sel_o
);

    // Retry counter must hold values 0..MAX_RETRY; keep at least one bit.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP,
        S_RESP_OK,
        S_RESP_ERR
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic [RW-1:0]   rcnt, rcnt_d;

    // Next values of every registered output.
    logic            cyc_d;
    logic            we_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdat_d;
    logic [SELW-1:0] sel_d;
    logic [DW-1:0]   rdat_d;
    logic            ack_d;
    logic            err_d;
    logic            tmo_d;

    // Next-state and next-output computation; everything is registered below.
    always_comb begin
        state_d = state;
        tcnt_d  = tcnt;
        rcnt_d  = rcnt;
        cyc_d   = wbs_cyc_o;
        we_d    = wbs_we_o;
        addr_d  = wbs_addr_o;
        wdat_d  = wbs_dat_o;
        sel_d   = wbs_sel_o;
        rdat_d  = wbm_dat_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state)
            S_IDLE: begin
                tcnt_d = '0;
                rcnt_d = '0;
                if (wbm_we_i || wbm_re_i) begin
                    // Write wins when both request lines are high.
                    we_d    = wbm_we_i;
                    addr_d  = wbm_addr_i;
                    wdat_d  = wbm_dat_i;
                    sel_d   = wbm_sel_i;
                    cyc_d   = 1'b1;
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (wbs_ack_i) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_RESP_OK;
                    if (!wbs_we_o) begin
                        rdat_d = wbs_dat_i;
                    end
                end else if (wbs_err_i && (rcnt < RW'(MAX_RETRY))) begin
                    cyc_d   = 1'b0;
                    rcnt_d  = rcnt + RW'(1);
                    state_d = S_GAP;
                end else if (wbs_err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP_ERR;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    // Silent slave: abort, never retried.
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP_ERR;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end

            S_GAP: begin
                // One idle bus cycle, then re-issue the latched request.
                tcnt_d  = '0;
                cyc_d   = 1'b1;
                state_d = S_ACTIVE;
            end

            S_RESP_OK, S_RESP_ERR: begin
                tcnt_d  = '0;
                rcnt_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                tcnt_d  = '0;
                rcnt_d  = '0;
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered; reset drops the bus at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            rcnt          <= '0;
            wbs_cyc_o     <= 1'b0;
            wbs_stb_o     <= 1'b0;
            wbs_we_o      <= 1'b0;
            wbs_addr_o    <= '0;
            wbs_dat_o     <= '0;
            wbs_sel_o     <= '0;
            wbm_dat_o     <= '0;
            wbm_ack_o     <= 1'b0;
            wbm_err_o     <= 1'b0;
            wbm_timeout_o <= 1'b0;
            wbm_busy_o    <= 1'b0;
        end else begin
            state         <= state_d;
            tcnt          <= tcnt_d;
            rcnt          <= rcnt_d;
            wbs_cyc_o     <= cyc_d;
            wbs_stb_o     <= cyc_d;
            wbs_we_o      <= we_d;
            wbs_addr_o    <= addr_d;
            wbs_dat_o     <= wdat_d;
            wbs_sel_o     <= sel_d;
            wbm_dat_o     <= rdat_d;
            wbm_ack_o     <= ack_d;
            wbm_err_o     <= err_d;
            wbm_timeout_o <= tmo_d;
            wbm_busy_o    <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: a transaction-level model expands
// each request into the cycle-by-cycle outputs it must produce, and a single
// compare process checks the DUT against that trace every cycle.
module tb_wb_master_bridge;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int SELW      = 4;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 255;
    localparam int TW        = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   wbm_dat_i = '0;
    logic [AW-1:0]   wbm_addr_i = '0;
    logic [SELW-1:0] wbm_sel_i = '0;
    logic            wbm_we_i = 1'b0;
    logic            wbm_re_i = 1'b0;
    logic            wbm_ack_o, wbm_err_o, wbm_busy_o, wbm_timeout_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW-1:0]   wbs_dat_i = '0;
    logic            wbs_ack_i = 1'b0;
    logic            wbs_err_i = 1'b0;
    logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [AW-1:0]   wbs_addr_o;
    logic [SELW-1:0] wbs_sel_o;

    wb_master_bridge #(
        .DW(DW), .AW(AW), .SELW(SELW), .MAX_RETRY(MAX_RETRY),
        .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wbm_dat_i(wbm_dat_i), .wbm_addr_i(wbm_addr_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_re_i(wbm_re_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_dat_o(wbm_dat_o),
        .wbm_busy_o(wbm_busy_o), .wbm_timeout_o(wbm_timeout_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_dat_o(wbs_dat_o),
        .wbs_addr_o(wbs_addr_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o)
    );

    always #5 clk = ~clk;

    // One clock of stimulus (applied before the edge) and the outputs the
    // bridge must show right after that edge.
    typedef struct {
        bit        we_i, re_i;
        bit [31:0] dat_i, addr_i;
        bit [3:0]  sel_i;
        bit        s_ack, s_err;
        bit [31:0] s_dat;
        bit        e_cyc, e_ack, e_err, e_tmo, e_busy, e_we;
        bit [31:0] e_dat, e_addr, e_wdat;
        bit [3:0]  e_sel;
    } rec_t;

    rec_t      q[$];
    rec_t      cur;
    bit        chk_en = 1'b0;
    int        tests = 0;
    int        fails = 0;
    bit [31:0] m_dat = '0;

    // Latched request of the transaction being modelled.
    bit        lat_we;
    bit [31:0] lat_addr, lat_wdat;
    bit [3:0]  lat_sel;

    // Monitor counters.
    int cyc_num = 0;
    int cyc_cycles = 0, stb_rises = 0, ack_cnt = 0, err_cnt = 0;
    int tmo_cnt = 0, both_cnt = 0, ack_at = 0;
    bit prev_cyc = 1'b0;
    bit we_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc_num, got, want);
        end
    endtask

    task automatic clr_mon();
        cyc_cycles = 0; stb_rises = 0; ack_cnt = 0; err_cnt = 0;
        tmo_cnt = 0; both_cnt = 0; ack_at = 0;
    endtask

    // Compare process: samples 1 ns after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc_num++;
            if (wbs_cyc_o) begin
                cyc_cycles++;
                we_seen = wbs_we_o;
            end
            if (wbs_cyc_o && !prev_cyc) stb_rises++;
            prev_cyc = wbs_cyc_o;
            if (wbm_ack_o) begin
                ack_cnt++;
                ack_at = cyc_num;
            end
            if (wbm_err_o) err_cnt++;
            if (wbm_timeout_o) tmo_cnt++;
            if (wbm_err_o && wbm_timeout_o) both_cnt++;
            if (chk_en) begin
                check("ctrl{cyc,stb,ack,err,tmo,busy}",
                      64'({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_timeout_o, wbm_busy_o}),
                      64'({cur.e_cyc, cur.e_cyc, cur.e_ack, cur.e_err, cur.e_tmo, cur.e_busy}));
                check("wbm_dat_o", 64'(wbm_dat_o), 64'(cur.e_dat));
                if (cur.e_cyc) begin
                    check("bus{we,sel,addr}", 64'({wbs_we_o, wbs_sel_o, wbs_addr_o}),
                          64'({cur.e_we, cur.e_sel, cur.e_addr}));
                    check("bus_wdat", 64'(wbs_dat_o), 64'(cur.e_wdat));
                end
            end
        end
    end

    // A record with random pipeline data and random slave junk, expecting idle.
    function automatic rec_t base(input bit we, input bit re);
        rec_t r;
        r.we_i   = we;
        r.re_i   = re;
        r.dat_i  = $urandom;
        r.addr_i = $urandom;
        r.sel_i  = 4'($urandom);
        r.s_ack  = 1'($urandom_range(0, 1));
        r.s_err  = 1'($urandom_range(0, 1));
        r.s_dat  = $urandom;
        r.e_cyc  = 1'b0;
        r.e_ack  = 1'b0;
        r.e_err  = 1'b0;
        r.e_tmo  = 1'b0;
        r.e_busy = 1'b0;
        r.e_we   = 1'b0;
        r.e_dat  = m_dat;
        r.e_addr = '0;
        r.e_wdat = '0;
        r.e_sel  = '0;
        return r;
    endfunction

    function automatic rec_t set_active(input rec_t r_in);
        rec_t r = r_in;
        r.e_cyc  = 1'b1;
        r.e_busy = 1'b1;
        r.e_we   = lat_we;
        r.e_addr = lat_addr;
        r.e_wdat = lat_wdat;
        r.e_sel  = lat_sel;
        return r;
    endfunction

    // Expand one transaction. Per attempt: wait count and response
    // (0 = ack, 1 = err, 2 = silent). rdat is returned on the acking cycle.
    task automatic add_txn(input int gap, input bit we, input bit re,
                           input bit [31:0] addr, input bit [31:0] wdat, input bit [3:0] sel,
                           input int w0, input int w1, input int w2,
                           input int r0, input int r1, input int r2,
                           input bit [31:0] rdat);
        int   waits[3];
        int   resp[3];
        int   rt = 0;
        int   a = 0;
        bit   done = 1'b0;
        rec_t r;
        waits = '{w0, w1, w2};
        resp  = '{r0, r1, r2};
        lat_we = we; lat_addr = addr; lat_wdat = wdat; lat_sel = sel;
        for (int i = 0; i < gap; i++) q.push_back(base(1'b0, 1'b0));
        r = base(we, re);
        r.addr_i = addr; r.dat_i = wdat; r.sel_i = sel;
        q.push_back(set_active(r));
        while (!done) begin
            int n;
            int outc;
            if (resp[a] == 2 || waits[a] >= TIMEOUT) begin
                n = TIMEOUT; outc = 2;
            end else begin
                n = waits[a] + 1; outc = resp[a];
            end
            for (int j = 0; j < n - 1; j++) begin
                r = base(we, re);
                r.s_ack = 1'b0; r.s_err = 1'b0;
                q.push_back(set_active(r));
            end
            r = base(we, re);
            r.s_ack = 1'b0; r.s_err = 1'b0;
            r.e_busy = 1'b1;
            if (outc == 0) begin
                r.s_ack = 1'b1;
                r.s_err = 1'($urandom_range(0, 1));
                r.s_dat = rdat;
                if (!we) m_dat = rdat;
                r.e_dat = m_dat;
                r.e_ack = 1'b1;
                done = 1'b1;
            end else if (outc == 1) begin
                r.s_err = 1'b1;
                if (rt < MAX_RETRY) begin
                    rt++;
                    a++;
                end else begin
                    r.e_err = 1'b1;
                    done = 1'b1;
                end
            end else begin
                r.e_err = 1'b1;
                r.e_tmo = 1'b1;
                done = 1'b1;
            end
            q.push_back(r);
            if (!done) q.push_back(set_active(base(we, re)));
        end
        // Response cycle: request still held, bridge returns to idle after it.
        q.push_back(base(we, re));
    endtask

    task automatic drive(input rec_t r);
        wbm_we_i   = r.we_i;
        wbm_re_i   = r.re_i;
        wbm_dat_i  = r.dat_i;
        wbm_addr_i = r.addr_i;
        wbm_sel_i  = r.sel_i;
        wbs_ack_i  = r.s_ack;
        wbs_err_i  = r.s_err;
        wbs_dat_i  = r.s_dat;
    endtask

    // Called 2 ns after an edge; leaves the bench idle and checked.
    task automatic play();
        while (q.size() > 0) begin
            cur = q.pop_front();
            drive(cur);
            chk_en = 1'b1;
            @(posedge clk);
            #2;
        end
        cur = base(1'b0, 1'b0);
        drive(cur);
    endtask

    initial begin
        int n0;
        int silent;
        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("reset_ctrl", 64'({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_timeout_o, wbm_busy_o, wbs_we_o}), 64'(0));
        check("reset_dat", 64'(wbm_dat_o), 64'(0));
        check("reset_addr", 64'(wbs_addr_o), 64'(0));
        rst_n = 1'b1;
        cur = base(1'b0, 1'b0);
        drive(cur);
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        // Zero-wait read.
        clr_mon();
        n0 = cyc_num;
        add_txn(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        play();
        check("read_dat", 64'(wbm_dat_o), 64'h0000_0000_DEAD_BEEF);
        check("read_cyc_len", 64'(cyc_cycles), 64'(1));
        check("read_ack_latency", 64'(ack_at - n0), 64'(2));
        check("read_ack_cnt", 64'(ack_cnt), 64'(1));
        check("read_we", 64'(we_seen), 64'(0));

        // Write with three wait states.
        clr_mon();
        add_txn(1, 1'b1, 1'b0, 32'h200, 32'h12345678, 4'h3, 3, 0, 0, 0, 0, 0, 32'h0);
        play();
        check("write_cyc_len", 64'(cyc_cycles), 64'(4));
        check("write_ack_cnt", 64'(ack_cnt), 64'(1));
        check("write_we", 64'(we_seen), 64'(1));
        check("write_dat_kept", 64'(wbm_dat_o), 64'h0000_0000_DEAD_BEEF);

        // Two errors then ack.
        clr_mon();
        add_txn(0, 1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 0, 0, 0, 1, 1, 0, 32'hCAFEF00D);
        play();
        check("retry_strobes", 64'(stb_rises), 64'(3));
        check("retry_ack", 64'(ack_cnt), 64'(1));
        check("retry_err", 64'(err_cnt), 64'(0));
        check("retry_dat", 64'(wbm_dat_o), 64'h0000_0000_CAFE_F00D);

        // Errors on every attempt.
        clr_mon();
        add_txn(2, 1'b1, 1'b0, 32'h340, 32'h55AA55AA, 4'hF, 1, 0, 2, 1, 1, 1, 32'h0);
        play();
        check("allerr_strobes", 64'(stb_rises), 64'(3));
        check("allerr_err", 64'(err_cnt), 64'(1));
        check("allerr_tmo", 64'(tmo_cnt), 64'(0));
        check("allerr_ack", 64'(ack_cnt), 64'(0));

        // Silent slave.
        clr_mon();
        add_txn(0, 1'b0, 1'b1, 32'h380, 32'h0, 4'h1, 0, 0, 0, 2, 0, 0, 32'h0);
        play();
        check("tmo_cyc_len", 64'(cyc_cycles), 64'(255));
        check("tmo_strobes", 64'(stb_rises), 64'(1));
        check("tmo_err_with_flag", 64'(both_cnt), 64'(1));
        check("tmo_err_cnt", 64'(err_cnt), 64'(1));
        check("tmo_dat_kept", 64'(wbm_dat_o), 64'h0000_0000_CAFE_F00D);

        // Reset in the second ACTIVE cycle.
        chk_en = 1'b0;
        clr_mon();
        wbm_re_i = 1'b1; wbm_we_i = 1'b0; wbm_addr_i = 32'h400; wbm_sel_i = 4'hF;
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rst_pre_cyc", 64'(wbs_cyc_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", 64'({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_busy_o}), 64'(0));
        check("rst_async_dat", 64'(wbm_dat_o), 64'(0));
        wbm_re_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_no_pulse", 64'(ack_cnt + err_cnt), 64'(0));
        rst_n = 1'b1;
        m_dat = '0;
        cur = base(1'b0, 1'b0);
        drive(cur);
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        // Both request lines high: the write is issued.
        clr_mon();
        add_txn(0, 1'b1, 1'b1, 32'h500, 32'hA5A50001, 4'hC, 1, 0, 0, 0, 0, 0, 32'h0BAD0BAD);
        play();
        check("both_we", 64'(we_seen), 64'(1));
        check("both_ack", 64'(ack_cnt), 64'(1));
        check("both_dat_kept", 64'(wbm_dat_o), 64'(0));

        // Randomised traffic, including back-to-back issue.
        silent = 0;
        for (int t = 0; t < 40; t++) begin
            int k;
            int w[3];
            int rs[3];
            bit we;
            bit re;
            k = $urandom_range(0, 2);
            we = (k != 1);
            re = (k != 0);
            for (int i = 0; i < 3; i++) begin
                int p;
                p = $urandom_range(0, 99);
                w[i] = $urandom_range(0, 4);
                rs[i] = (p < 65) ? 0 : (p < 95) ? 1 : 2;
                if (rs[i] == 2) begin
                    if (silent >= 3) rs[i] = 1;
                    else silent++;
                end
            end
            add_txn($urandom_range(0, 3), we, re, $urandom, $urandom, 4'($urandom),
                    w[0], w[1], w[2], rs[0], rs[1], rs[2], $urandom);
            play();
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
